rr_mux_arbiter: RTL

Round-robin arbiter that shares one 4:1 multiplexer datapath among four requesters.
- Each requester presents WIDTH-bit data plus a request line.
- The arbiter drives the mux select, returns a one-hot grant, and presents the selected data to a single downstream consumer with a valid/ready handshake.
- A grantee may hold the path for up to HOLD_MAX transfers before it must yield.

---
 rtl/rr_mux_arbiter_pkg.sv | 19 +
 rtl/rr_mux_arbiter_if.sv | 38 +++
 rtl/rr_mux_arbiter_pick4.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter_pkg
// Shared definitions for the round-robin mux arbiter:
//   - NREQ          : number of requesters sharing the datapath
//   - ST_IDLE/GRANT : FSM state encoding
//   - onehot4()     : converts a 2-bit requester index into a one-hot grant
// ----------------------------------------------------------------------------
package rr_mux_arbiter_pkg;

    localparam int NREQ = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter_if
// Bundles the requester side and the downstream side of the arbiter.
//   req[3:0]      : request per requester (bit0=a .. bit3=d)
//   a, b, c, d    : requester data, WIDTH bits each
//   out_ready     : downstream accepts data this cycle
//   sel[1:0]      : registered mux select
//   gnt[3:0]      : registered one-hot grant, zero when idle
//   out_data      : selected requester data
//   out_valid     : selected data is valid
// Modports:
//   slave  - the arbiter itself
//   master - the environment driving requests and consuming output
// ----------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_ready;
    logic [1:0]       sel;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    modport slave (
        input  req, a, b, c, d, out_ready,
        output sel, gnt, out_data, out_valid
    );

    modport master (
        output req, a, b, c, d, out_ready,
        input  sel, gnt, out_data, out_valid
    );
endinterface

// File: rtl/rr_mux_arbiter_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4
// Purely combinational round-robin picker for four requesters.
//   req[3:0]    : request vector
//   ptr[1:0]    : highest-priority index; scan goes ptr, ptr+1, ... wrapping
//   any         : at least one request is set
//   winner[1:0] : first set request at or above ptr (modulo 4)
// ----------------------------------------------------------------------------
module rr_pick4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            any,
    output logic [1:0]      winner
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            // 2-bit addition wraps 3 -> 0 naturally.
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter sharing one 4:1 mux datapath among four requesters.
// A grantee keeps the path for up to HOLD_MAX transfers, then yields to the
// next requester in round-robin order. Hand-over between grantees happens
// without an idle cycle.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : rr_mux_arbiter_if.slave (requests, data, handshake, grant)
// Parameters:
//   WIDTH    : data width
//   HOLD_MAX : max consecutive transfers per grant (1..16)
// ----------------------------------------------------------------------------
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_mux_arbiter_if.slave     bus
);

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       sel_q,   sel_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [1:0]       pick_ptr;
    logic             pick_any;
    logic [1:0]       pick_winner;
    logic             valid;
    logic             xfer;
    logic             release_gnt;

    // While granted the only use of the picker is on release, where the
    // pointer advances to just past the current grantee; in IDLE the stored
    // pointer is used directly.
    assign pick_ptr = (state_q == ST_GRANT) ? (sel_q + 2'd1) : ptr_q;

    rr_pick4 u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign valid       = (state_q == ST_GRANT) && bus.req[sel_q];
    assign xfer        = valid && bus.out_ready;
    // Withdrawal releases immediately; otherwise release on the last
    // allowed transfer of the burst.
    assign release_gnt = !bus.req[sel_q] || (xfer && (cnt_q == CNT_LAST));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_winner;
                    gnt_d   = onehot4(pick_winner);
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (release_gnt) begin
                    ptr_d = sel_q + 2'd1;
                    cnt_d = '0;
                    if (pick_any) begin
                        sel_d = pick_winner;
                        gnt_d = onehot4(pick_winner);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Under backpressure everything holds; no timeout by design.
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.out_data = bus.a;
        case (sel_q)
            2'd0:    bus.out_data = bus.a;
            2'd1:    bus.out_data = bus.b;
            2'd2:    bus.out_data = bus.c;
            default: bus.out_data = bus.d;
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = valid;

endmodule
